// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// stream and writes it as 32-bit words into instruction memory.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [15:0]       len_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        xor_q;
    logic [23:0]       buf_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        accept;
    logic        take_start;
    logic        last_word;
    logic [15:0] len_n;

    assign accept     = s_valid && s_ready;
    assign take_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign len_n      = {s_data, len_q[7:0]};
    assign last_word  = (32'(word_idx_q) + 32'd1) == 32'(len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_n == 16'd0)                      state_d = S_CHK;
                    else if (32'(len_n) > 32'(MAX_WORDS))    state_d = S_ERR;
                    else                                     state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_idx_q == 2'd3 && last_word) state_d = S_CHK;
            end
            S_CHK: begin
                if (accept) state_d = (s_data == xor_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        core_rst = 1'b1;
        unique case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            S_DONE:  begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // Word write is registered so the strobe lands in the cycle after the 4th byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
            buf_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (take_start) begin
                word_idx_q <= '0;
                byte_idx_q <= '0;
                xor_q      <= '0;
            end else if (accept) begin
                unique case (state_q)
                    S_LEN_LO: len_q[7:0]  <= s_data;
                    S_LEN_HI: len_q[15:8] <= s_data;
                    S_DATA: begin
                        xor_q      <= xor_q ^ s_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: buf_q[7:0]   <= s_data;
                            2'd1: buf_q[15:8]  <= s_data;
                            2'd2: buf_q[23:16] <= s_data;
                            default: begin
                                we_q    <= 1'b1;
                                addr_q  <= word_idx_q;
                                wdata_q <= {s_data, buf_q};
                                if (!last_word) word_idx_q <= word_idx_q + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: streams byte sequences and checks memory
// writes and the final status flags against hand-computed values.
module tb_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    logic              gap_mode;
    int                pulse_at;

    prog_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write strobe lasts one cycle, so one negedge sample per write.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_eq("ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        if (gap_mode) tick();
    endtask

    task automatic send_stream();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (i == pulse_at) begin
                pulse_start();
                check_eq("busy_after_start_in_data", 32'(busy), 32'd1);
                check_eq("ready_after_start_in_data", 32'(s_ready), 32'd1);
            end
        end
    endtask

    task automatic check_two_words(input string tag);
        check_eq({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check_eq({tag, "_a0"}, 32'(wa[0]), 32'd0);
            check_eq({tag, "_d0"}, wd[0], 32'h0010_0113);
            check_eq({tag, "_a1"}, 32'(wa[1]), 32'd1);
            check_eq({tag, "_d1"}, wd[1], 32'h0021_00B3);
        end
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err);
        check_eq({tag, "_done"},     32'(done),     32'(e_done));
        check_eq({tag, "_err"},      32'(err),      32'(e_err));
        check_eq({tag, "_core_rst"}, 32'(core_rst), 32'(!e_done));
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
        check_eq({tag, "_ready"},    32'(s_ready),  32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},    32'(s_ready),  32'd0);
        check_eq({tag, "_we"},       32'(imem_we),  32'd0);
        check_eq({tag, "_addr"},     32'(imem_addr), 32'd0);
        check_eq({tag, "_wdata"},    imem_wdata,    32'd0);
        check_eq({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
        check_eq({tag, "_done"},     32'(done),     32'd0);
        check_eq({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic new_load();
        wa.delete();
        wd.delete();
        pulse_start();
        check_eq("load_busy", 32'(busy), 32'd1);
        check_eq("load_core_rst", 32'(core_rst), 32'd1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        gap_mode = 1'b0;
        pulse_at = -1;
        #1;
        check_reset_outputs("rst0");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("idle_no_start_busy", 32'(busy), 32'd0);

        // Payload XOR: 13^01^10^00^B3^00^21^00 = 0x90.
        new_load();
        stim = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                 8'hB3, 8'h00, 8'h21, 8'h00, 8'h90};
        send_stream();
        check_two_words("good");
        check_status("good", 1'b1, 1'b0);
        tick();
        check_eq("hold_addr", 32'(imem_addr), 32'd1);
        check_eq("hold_wdata", imem_wdata, 32'h0021_00B3);

        new_load();
        stim[10] = 8'h00;
        send_stream();
        check_two_words("bad00");
        check_status("bad00", 1'b0, 1'b1);

        new_load();
        stim[10] = 8'hA1;
        send_stream();
        check_two_words("badA1");
        check_status("badA1", 1'b0, 1'b1);

        new_load();
        stim = '{8'h01, 8'h01};
        send_stream();
        check_status("n257", 1'b0, 1'b1);
        check_eq("n257_nwr", 32'(wa.size()), 32'd0);

        new_load();
        stim = '{8'h00, 8'h00, 8'h00};
        send_stream();
        check_status("n0", 1'b1, 1'b0);
        check_eq("n0_nwr", 32'(wa.size()), 32'd0);

        new_load();
        stim = '{8'h00, 8'h00, 8'h55};
        send_stream();
        check_status("n0bad", 1'b0, 1'b1);
        check_eq("n0bad_nwr", 32'(wa.size()), 32'd0);

        new_load();
        gap_mode = 1'b1;
        pulse_at = 5;
        stim = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                 8'hB3, 8'h00, 8'h21, 8'h00, 8'h90};
        send_stream();
        gap_mode = 1'b0;
        pulse_at = -1;
        check_two_words("gap");
        check_status("gap", 1'b1, 1'b0);

        new_load();
        stim = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hB3, 8'h00};
        send_stream();
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check_eq("midrst_a0", 32'(wa[0]), 32'd0);
            check_eq("midrst_d0", wd[0], 32'h0010_0113);
        end

        new_load();
        stim = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                 8'hB3, 8'h00, 8'h21, 8'h00, 8'h90};
        send_stream();
        check_two_words("restart");
        check_status("restart", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
